// File: rtl/ram_port_arbiter.sv
// Arbitrates the single RAM data port between the CPU load/store unit and the
// debug/loader master: CPU priority, bounded debug starvation, bounded debug lock bursts.
module ram_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_mode,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [2:0]  dbg_mode,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic        dbg_lock,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic [2:0]  ram_mode,
  output logic [31:0] ram_addr,
  output logic        ram_is_store,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);

  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]    state;
  logic [SW-1:0] starve_cnt;
  logic [LW-1:0] lock_cnt;
  logic          leave_lock;
  logic          cpu_rvalid_q;
  logic          dbg_rvalid_q;

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      if (state == LOCK) begin
        dbg_gnt = dbg_req;
      end else begin
        dbg_gnt = dbg_req && (!cpu_req || starve_cnt == SW'(MAX_WAIT));
        cpu_gnt = cpu_req && !dbg_gnt;
      end
    end
  end

  // A locked burst ends when debug lets go, or once the beat just granted reaches LOCK_MAX.
  assign leave_lock = (state == LOCK) &&
                      (!(dbg_req && dbg_lock) || (lock_cnt + LW'(1) == LW'(LOCK_MAX)));

  always_comb begin
    ram_mode     = cpu_mode;
    ram_addr     = '0;
    ram_wdata    = '0;
    ram_is_store = 1'b0;
    if (dbg_gnt) begin
      ram_mode     = dbg_mode;
      ram_addr     = dbg_addr;
      ram_wdata    = dbg_wdata;
      ram_is_store = dbg_we;
    end else if (cpu_gnt) begin
      ram_addr     = cpu_addr;
      ram_wdata    = cpu_wdata;
      ram_is_store = cpu_we;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB;
      starve_cnt   <= '0;
      lock_cnt     <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata    <= '0;
      dbg_rdata    <= '0;
    end else begin
      if (state == ARB) begin
        if (dbg_gnt && dbg_lock) begin
          state    <= LOCK;
          lock_cnt <= LW'(1);
        end
      end else if (leave_lock) begin
        state    <= ARB;
        lock_cnt <= '0;
      end else begin
        lock_cnt <= lock_cnt + LW'(1);
      end

      // Clearing on lock exit hands the first ARB cycle back to the CPU.
      if (leave_lock || dbg_gnt || !dbg_req) begin
        starve_cnt <= '0;
      end else if (cpu_gnt && starve_cnt != SW'(MAX_WAIT)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end

      cpu_rvalid_q <= cpu_gnt && !cpu_we;
      dbg_rvalid_q <= dbg_gnt && !dbg_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= ram_rdata;
      if (dbg_gnt && !dbg_we) dbg_rdata <= ram_rdata;
    end
  end

  // Masking with rst drops the response of a load granted just before reset.
  assign cpu_rvalid = cpu_rvalid_q && !rst;
  assign dbg_rvalid = dbg_rvalid_q && !rst;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and random checks of ram_port_arbiter against a word-wide RAM model
// owned by the bench; RAM contents reload to a known pattern on rst.
module tb_ram_port_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [2:0]  cpu_mode;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req, dbg_we, dbg_lock;
  logic [2:0]  dbg_mode;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [2:0]  ram_mode;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_is_store;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:255];

  ram_port_arbiter #(.MAX_WAIT(4), .LOCK_MAX(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_mode(cpu_mode),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_mode(dbg_mode),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_mode(ram_mode), .ram_addr(ram_addr), .ram_is_store(ram_is_store),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr[9:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
      mem[4] <= 32'hDEAD_BEEF;
    end else if (ram_is_store) begin
      mem[ram_addr[9:2]] <= ram_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 1'b0;
  endtask

  initial begin
    int          beat;
    int          good;
    int          wait_cnt;
    logic        cpu_done, dbg_done;
    logic        prev_cg, prev_dg;
    logic        exp_cpu_rv, exp_dbg_rv;
    logic [31:0] exp_cpu_d, exp_dbg_d;

    idle();
    cpu_mode = 3'd2;
    dbg_mode = 3'd5;
    rst = 1'b1;
    step();
    step();

    // Requests during reset must not be granted.
    cpu_req = 1'b1; cpu_we = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1;
    @(negedge clk);
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_dbg_gnt", dbg_gnt, 0);
    check("rst_store", ram_is_store, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    step();
    rst = 1'b0;
    idle();

    // Test 1: single CPU load, registered response.
    cpu_req = 1'b1; cpu_addr = 32'h10;
    @(negedge clk);
    check("t1_cpu_gnt", cpu_gnt, 1);
    check("t1_dbg_gnt", dbg_gnt, 0);
    check("t1_ram_addr", ram_addr, 32'h10);
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    check("t1_rvalid", cpu_rvalid, 1);
    check("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    step();
    @(negedge clk);
    check("t1_rvalid_pulse", cpu_rvalid, 0);
    check("t1_idle_addr", ram_addr, 0);
    check("t1_idle_mode", ram_mode, 3'd2);
    step();

    // Test 2: CPU streams loads; debug load forced in after MAX_WAIT pass-overs.
    dbg_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
      dbg_req = !dbg_done; dbg_we = 1'b0; dbg_addr = 32'h24;
      @(negedge clk);
      check($sformatf("t2_dbg_gnt_c%0d", c), dbg_gnt, (c == 4));
      check($sformatf("t2_cpu_gnt_c%0d", c), cpu_gnt, (c != 4));
      check($sformatf("t2_cpu_rv_c%0d", c), cpu_rvalid, (c >= 1 && c != 5));
      if (c == 5) begin
        check("t2_dbg_rvalid", dbg_rvalid, 1);
        check("t2_dbg_rdata", dbg_rdata, 32'hC0DE_0009);
      end
      if (dbg_gnt) dbg_done = 1'b1;
      step();
    end
    idle();

    // Test 3: 20-beat locked debug store burst with a CPU load waiting.
    beat = 0;
    cpu_done = 1'b0;
    for (int c = 0; c < 22; c++) begin
      dbg_req = (beat < 20); dbg_lock = (beat < 20); dbg_we = 1'b1;
      dbg_addr = 32'h100 + 32'(beat) * 4; dbg_wdata = 32'hA000_0000 + 32'(beat);
      cpu_req = (c >= 1) && !cpu_done; cpu_we = 1'b0; cpu_addr = 32'h80;
      @(negedge clk);
      check($sformatf("t3_dbg_gnt_c%0d", c), dbg_gnt, (c <= 15) || (c >= 17 && c <= 20));
      check($sformatf("t3_cpu_gnt_c%0d", c), cpu_gnt, (c == 16));
      if (c == 17) begin
        check("t3_cpu_rvalid", cpu_rvalid, 1);
        check("t3_cpu_rdata", cpu_rdata, 32'hC0DE_0020);
      end
      if (dbg_gnt) beat++;
      if (cpu_gnt) cpu_done = 1'b1;
      step();
    end
    idle();
    good = 0;
    for (int k = 0; k < 20; k++) if (mem[64 + k] === 32'hA000_0000 + 32'(k)) good++;
    check("t3_burst_words", good, 20);

    // Test 4: debug store then CPU load of the same word on the next cycle.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'h55AA_55AA;
    @(negedge clk);
    check("t4_dbg_gnt", dbg_gnt, 1);
    check("t4_store", ram_is_store, 1);
    check("t4_wdata", ram_wdata, 32'h55AA_55AA);
    step();
    idle();
    cpu_req = 1'b1; cpu_addr = 32'h40;
    @(negedge clk);
    check("t4_cpu_gnt", cpu_gnt, 1);
    check("t4_no_store_rvalid", dbg_rvalid, 0);
    step();
    idle();
    @(negedge clk);
    check("t4_rvalid", cpu_rvalid, 1);
    check("t4_rdata", cpu_rdata, 32'h55AA_55AA);
    step();

    // Test 5: reset in the middle of a locked burst.
    dbg_req = 1'b1; dbg_lock = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h200; dbg_wdata = 32'h1;
    @(negedge clk);
    check("t5_lock_gnt", dbg_gnt, 1);
    step();
    dbg_we = 1'b0; dbg_addr = 32'h204;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h84;
    @(negedge clk);
    check("t5_locked_dbg", dbg_gnt, 1);
    check("t5_locked_cpu", cpu_gnt, 0);
    step();
    rst = 1'b1; dbg_we = 1'b1;
    @(negedge clk);
    check("t5_rst_cpu_gnt", cpu_gnt, 0);
    check("t5_rst_dbg_gnt", dbg_gnt, 0);
    check("t5_rst_store", ram_is_store, 0);
    check("t5_rst_rvalid", dbg_rvalid, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t5_post_cpu_gnt", cpu_gnt, 1);
    check("t5_post_dbg_gnt", dbg_gnt, 0);
    step();
    idle();
    @(negedge clk);
    check("t5_post_rvalid", cpu_rvalid, 1);
    check("t5_post_rdata", cpu_rdata, 32'hC0DE_0021);
    step();

    // Test 6: random traffic, requests held until granted.
    prev_cg = 1'b0; prev_dg = 1'b0;
    exp_cpu_rv = 1'b0; exp_dbg_rv = 1'b0;
    exp_cpu_d = '0; exp_dbg_d = '0;
    wait_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      if (cpu_req && prev_cg) cpu_req = 1'b0;
      if (!cpu_req && $urandom_range(0, 1) == 1) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 32'($urandom_range(0, 63)) << 2; cpu_wdata = $urandom;
      end
      if (dbg_req && prev_dg) dbg_req = 1'b0;
      if (!dbg_req && $urandom_range(0, 1) == 1) begin
        dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
        dbg_lock = ($urandom_range(0, 3) != 0);
        dbg_addr = 32'($urandom_range(0, 63)) << 2; dbg_wdata = $urandom;
      end
      @(negedge clk);
      check("rnd_exclusive", cpu_gnt & dbg_gnt, 0);
      check("rnd_gnt_without_req", (cpu_gnt & !cpu_req) | (dbg_gnt & !dbg_req), 0);
      check("rnd_cpu_rvalid", cpu_rvalid, exp_cpu_rv);
      check("rnd_dbg_rvalid", dbg_rvalid, exp_dbg_rv);
      if (exp_cpu_rv) check("rnd_cpu_rdata", cpu_rdata, exp_cpu_d);
      if (exp_dbg_rv) check("rnd_dbg_rdata", dbg_rdata, exp_dbg_d);
      if (cpu_gnt) check("rnd_cpu_addr", ram_addr, cpu_addr);
      if (dbg_gnt) check("rnd_dbg_addr", ram_addr, dbg_addr);
      if (dbg_req && !dbg_gnt) wait_cnt++;
      else wait_cnt = 0;
      check("rnd_starve_bound", (wait_cnt <= MAX_WAIT), 1);
      exp_cpu_rv = cpu_gnt && !cpu_we;
      exp_dbg_rv = dbg_gnt && !dbg_we;
      if (exp_cpu_rv) exp_cpu_d = mem[cpu_addr[9:2]];
      if (exp_dbg_rv) exp_dbg_d = mem[dbg_addr[9:2]];
      prev_cg = cpu_gnt;
      prev_dg = dbg_gnt;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
